// File: rtl/lvds_pkg.sv
// Shared constants and helpers for the LVDS capture packer.
// Mode encoding, clog2 and the sample-count width.
package lvds_pkg;

  localparam logic [1:0] MODE_ALL    = 2'd0;
  localparam logic [1:0] MODE_STROB  = 2'd1;
  localparam logic [1:0] MODE_CHANGE = 2'd2;
  localparam logic [1:0] MODE_OFF    = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int cnt_w(input int pack);
    return clog2(pack + 1);
  endfunction

endpackage

// File: rtl/lvds_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Pointers carry one extra wrap bit so fill is a plain subtraction.
module lvds_sync_fifo
  import lvds_pkg::*;
#(
  parameter int W     = 35,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [W-1:0]              din,
  input  logic                      pop,
  output logic [W-1:0]              dout,
  output logic                      full,
  output logic                      empty,
  output logic [clog2(DEPTH+1)-1:0] fill
);

  localparam int AW = clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW])
              && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign fill  = wptr - rptr;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Empty reads as zero so the head never shows stale words.
  assign dout = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/lvds_capture_packer.sv
// LVDS sample qualifier and packer feeding a FWFT output FIFO.
// Words enter the FIFO one edge after the packer completes them.
module lvds_capture_packer
  import lvds_pkg::*;
#(
  parameter int LVDS_LEN   = 8,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [1:0]                     mode,
  input  logic [LVDS_LEN-1:0]            ch_mask,
  input  logic [LVDS_LEN-1:0]            data_in,
  input  logic                           strob_in,
  input  logic                           flush,
  input  logic                           clr_ovf,
  output logic [LVDS_LEN*PACK-1:0]       out_data,
  output logic [cnt_w(PACK)-1:0]         out_cnt,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           overflow,
  output logic [clog2(FIFO_DEPTH+1)-1:0] fill
);

  localparam int CW = cnt_w(PACK);
  localparam int DW = LVDS_LEN * PACK;
  localparam logic [CW-1:0] PACK_C = CW'(PACK);

  logic [LVDS_LEN-1:0] s1;
  logic [LVDS_LEN-1:0] prev;
  logic                st1;
  logic                qual;
  logic                accept;

  logic [CW-1:0] idx;
  logic [CW-1:0] idx_nxt;
  logic [DW-1:0] slots;
  logic [DW-1:0] slots_nxt;
  logic          emit;

  logic          pk_valid;
  logic [DW-1:0] pk_data;
  logic [CW-1:0] pk_cnt;

  logic             f_full;
  logic             f_empty;
  logic [DW+CW-1:0] f_dout;
  logic             pop;
  logic             drop;

  always_comb begin
    qual = 1'b0;
    unique case (mode)
      MODE_ALL:    qual = 1'b1;
      MODE_STROB:  qual = st1;
      MODE_CHANGE: qual = (s1 != prev);
      MODE_OFF:    qual = 1'b0;
    endcase
    accept = en & qual;
  end

  always_comb begin
    slots_nxt = slots;
    for (int i = 0; i < PACK; i++) begin
      if (accept && idx == CW'(i))
        slots_nxt[i*LVDS_LEN +: LVDS_LEN] = s1;
    end
    idx_nxt = idx + CW'(accept);
    // A flush counts the same-edge accept before deciding.
    emit = (idx_nxt == PACK_C)
         | (flush & (idx_nxt != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      st1      <= 1'b0;
      prev     <= '0;
      idx      <= '0;
      slots    <= '0;
      pk_valid <= 1'b0;
      pk_data  <= '0;
      pk_cnt   <= '0;
    end else begin
      s1       <= data_in & ch_mask;
      st1      <= strob_in;
      prev     <= s1;
      pk_valid <= emit;
      if (emit) begin
        pk_data <= slots_nxt;
        pk_cnt  <= idx_nxt;
      end
      slots <= emit ? '0 : slots_nxt;
      idx   <= emit ? '0 : idx_nxt;
    end
  end

  assign out_valid = ~f_empty;
  assign pop       = out_valid & out_ready;
  assign drop      = pk_valid & f_full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  lvds_sync_fifo #(
    .W     (DW + CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pk_valid),
    .din   ({pk_cnt, pk_data}),
    .pop   (pop),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .fill  (fill)
  );

  assign out_data = f_dout[DW-1:0];
  assign out_cnt  = f_dout[DW +: CW];

endmodule

// File: tb/tb_lvds_capture_packer.sv
// Bench for lvds_capture_packer: directed scenarios plus random traffic,
// checked against a queue-based model of the sample/word flow.
module tb_lvds_capture_packer;
  import lvds_pkg::*;

  localparam int L  = 8;
  localparam int P  = 4;
  localparam int D  = 4;
  localparam int CW = cnt_w(P);
  localparam int FW = clog2(D + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [1:0]     mode = MODE_OFF;
  logic [L-1:0]   ch_mask = '1;
  logic [L-1:0]   data_in = '0;
  logic           strob_in = 1'b0;
  logic           flush = 1'b0;
  logic           clr_ovf = 1'b0;
  logic [L*P-1:0] out_data;
  logic [CW-1:0]  out_cnt;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           overflow;
  logic [FW-1:0]  fill;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [L*P-1:0] d;
    logic [CW-1:0]  c;
  } word_t;

  logic [L-1:0] m_s1;
  logic [L-1:0] m_prev;
  logic         m_st1;
  logic [L-1:0] part[$];
  word_t        q[$];
  word_t        pend;
  bit           pend_v;
  bit           m_ovf;

  logic [L-1:0] t_mask = '1;
  logic         t_st = 1'b0;
  logic         t_fl = 1'b0;
  logic         t_rdy = 1'b0;
  logic         t_clr = 1'b0;

  lvds_capture_packer #(
    .LVDS_LEN   (L),
    .PACK       (P),
    .FIFO_DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .ch_mask   (ch_mask),
    .data_in   (data_in),
    .strob_in  (strob_in),
    .flush     (flush),
    .clr_ovf   (clr_ovf),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .fill      (fill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_s1   = '0;
    m_prev = '0;
    m_st1  = 1'b0;
    part.delete();
    q.delete();
    pend   = '0;
    pend_v = 0;
    m_ovf  = 0;
  endtask

  function automatic word_t pack_part();
    word_t w;
    w = '0;
    foreach (part[i]) w.d[i*L +: L] = part[i];
    w.c = CW'(part.size());
    return w;
  endfunction

  // One clock: drive inputs, advance the model across the edge, compare.
  task automatic step(input logic [L-1:0] d, input logic e,
                      input logic [1:0] md);
    bit    pop;
    bit    acc;
    bit    drop;
    bit    nv;
    word_t nw;
    data_in = d; en = e; mode = md; ch_mask = t_mask;
    strob_in = t_st; flush = t_fl; out_ready = t_rdy; clr_ovf = t_clr;
    pop  = (q.size() != 0) && t_rdy;
    if (pop) void'(q.pop_front());
    drop = 0;
    if (pend_v) begin
      if (q.size() < D) q.push_back(pend);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (t_clr) m_ovf = 0;
    acc = e && (md == MODE_ALL || (md == MODE_STROB && m_st1)
             || (md == MODE_CHANGE && m_s1 != m_prev));
    if (acc) part.push_back(m_s1);
    nv = 0;
    nw = '0;
    if (part.size() == P || (t_fl && part.size() != 0)) begin
      nw = pack_part();
      nv = 1;
      part.delete();
    end
    pend   = nw;
    pend_v = nv;
    m_prev = m_s1;
    m_s1   = d & t_mask;
    m_st1  = t_st;
    @(posedge clk);
    #1;
    chk("valid", out_valid, q.size() != 0);
    chk("fill", fill, q.size());
    chk("ovf", overflow, m_ovf);
    if (q.size() != 0) begin
      chk("data", out_data, q[0].d);
      chk("cnt", out_cnt, q[0].c);
    end else begin
      chk("data_idle", out_data, 0);
    end
    t_fl  = 1'b0;
    t_clr = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [31:0] d,
                             input logic [CW-1:0] c);
    int n;
    n = 0;
    while (!out_valid && n < 8) begin
      step(data_in, 1'b0, MODE_OFF);
      n++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_cnt"}, out_cnt, c);
  endtask

  task automatic drain();
    int n;
    n = 0;
    t_rdy = 1'b1;
    while ((q.size() != 0 || pend_v || out_valid) && n < 16) begin
      step(data_in, 1'b0, MODE_OFF);
      n++;
    end
    t_rdy = 1'b0;
    chk("drained", fill, 0);
  endtask

  initial begin
    m_reset();
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_fill", fill, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", out_data, 0);
    chk("rst_cnt", out_cnt, 0);
    #9 rst_n = 1'b1;

    // Every-cycle capture of 01..04.
    step(8'h01, 1'b0, MODE_ALL);
    step(8'h02, 1'b1, MODE_ALL);
    step(8'h03, 1'b1, MODE_ALL);
    step(8'h04, 1'b1, MODE_ALL);
    step(8'h00, 1'b1, MODE_ALL);
    chk("t1_early", out_valid, 0);
    step(8'h00, 1'b0, MODE_ALL);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 32'h04030201);
    chk("t1_cnt", out_cnt, 4);
    drain();

    // Strobe-gated capture, then flush a partial word.
    for (int i = 0; i < 8; i++) begin
      t_st = (i == 3 || i == 6);
      step(L'(i), 1'b1, MODE_STROB);
    end
    t_st = 1'b0;
    step(8'h00, 1'b1, MODE_STROB);
    t_fl = 1'b1;
    step(8'h00, 1'b1, MODE_STROB);
    expect_head("t2", 32'h00000603, 2);
    drain();

    // On-change capture with a 0F mask; flush lands with an accept.
    t_mask = 8'h0F;
    step(8'h10, 1'b0, MODE_CHANGE);
    step(8'h11, 1'b1, MODE_CHANGE);
    step(8'h11, 1'b1, MODE_CHANGE);
    step(8'h21, 1'b1, MODE_CHANGE);
    step(8'h22, 1'b1, MODE_CHANGE);
    t_fl = 1'b1;
    step(8'h22, 1'b1, MODE_CHANGE);
    expect_head("t3", 32'h00000201, 2);
    t_mask = '1;
    drain();

    // 24 samples into a 4-word FIFO that nobody reads.
    for (int i = 0; i < 25; i++)
      step(L'(i + 1), i >= 1, MODE_ALL);
    step(8'h00, 1'b0, MODE_ALL);
    chk("t4_fill", fill, 4);
    chk("t4_ovf", overflow, 1);
    chk("t4_head", out_data, 32'h04030201);
    t_clr = 1'b1;
    step(8'h00, 1'b0, MODE_ALL);
    chk("t4_clr", overflow, 0);

    // Push into a full FIFO in the same cycle as a pop.
    for (int i = 0; i < 6; i++) begin
      t_rdy = (i == 5);
      step(L'(8'h30 + i), i >= 1 && i <= 4, MODE_ALL);
    end
    t_rdy = 1'b0;
    chk("t5_fill", fill, 4);
    chk("t5_ovf", overflow, 0);
    drain();

    // Asynchronous reset with 3 words queued and 2 samples packed.
    for (int i = 0; i < 15; i++)
      step(L'(i + 1), i >= 1, MODE_ALL);
    step(8'h00, 1'b0, MODE_ALL);
    chk("t6_pre_fill", fill, 3);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_fill", fill, 0);
    chk("t6_ovf", overflow, 0);
    m_reset();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++)
      step(L'(8'hA1 + i), i >= 1, MODE_ALL);
    expect_head("t6", 32'hA4A3A2A1, 4);
    drain();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) t_mask = L'($urandom);
      t_st  = 1'($urandom_range(1));
      t_fl  = ($urandom_range(9) == 0);
      t_rdy = 1'($urandom_range(1));
      t_clr = ($urandom_range(19) == 0);
      step(L'($urandom), $urandom_range(9) < 7,
           2'($urandom_range(3)));
    end
    t_rdy = 1'b0;
    t_fl  = 1'b1;
    step(data_in, 1'b0, MODE_OFF);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
